// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encodings, the default register-specifier width and the hardwired-zero register.
// Optional build macro for the whole slice: HAZARD_PERF_EN (performance counters).
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } hz_state_t;

  localparam int REG_W_DEF = 4;

  localparam logic [REG_W_DEF-1:0] ZERO_REG = 4'h0;

endpackage

// File: rtl/hazard_unit_perf_counters.sv
// Free-running event counters for stall, flush and freeze cycles.
// Latency: count visible the cycle after the event; wraps at 2^32.
// Only instantiated when HAZARD_PERF_EN is defined.
module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  input  logic        freeze_evt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_freeze_cnt
);

  // One increment per asserted event cycle; natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= 32'd0;
      perf_flush_cnt  <= 32'd0;
      perf_freeze_cnt <= 32'd0;
    end else begin
      if (stall_evt)  perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (flush_evt)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
      if (freeze_evt) perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, freeze on memory wait.
// Latency: all controls combinational from state and inputs; FSM/timeout registered.
// Optional macro HAZARD_PERF_EN adds live perf counters; otherwise perf ports read 0.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             dx_memread,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [1:0]       hz_state,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
  output logic [31:0]      perf_freeze_cnt
);

  // Last counter value before the wait is declared timed out: the increment
  // from this value would reach MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  hz_state_t        state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  logic freeze_c;
  logic load_use_c;
  logic flush_c;
  logic stall_c;

  // Freeze dominates, then branch flush, then load-use; flush/stall only in RUN.
  always_comb begin
    freeze_c   = 1'b0;
    load_use_c = 1'b0;
    flush_c    = 1'b0;
    stall_c    = 1'b0;
    case (state)
      ST_RUN:      freeze_c = mem_req & ~mem_ready;
      ST_MEM_WAIT: freeze_c = ~mem_ready;
      default:     freeze_c = 1'b1;
    endcase
    load_use_c = dx_memread && (dx_rd != REG_W'(ZERO_REG)) &&
                 ((id_uses_rs && (id_rs == dx_rd)) || (id_uses_rt && (id_rt == dx_rd)));
    flush_c    = (state == ST_RUN) && !freeze_c && ex_branch_taken;
    stall_c    = (state == ST_RUN) && !freeze_c && !ex_branch_taken && load_use_c;
  end

  // Memory-wait FSM with saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt >= TIMEOUT_LAST) begin
              state     <= ST_ERR;
              timeout_q <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Everything is held low while reset is asserted.
  assign freeze      = freeze_c & ~rst;
  assign ifid_flush  = flush_c  & ~rst;
  assign idex_flush  = flush_c  & ~rst;
  assign pc_stall    = stall_c  & ~rst;
  assign ifid_stall  = stall_c  & ~rst;
  assign idex_bubble = stall_c  & ~rst;
  assign mem_timeout = timeout_q & ~rst;
  assign hz_state    = rst ? 2'b00 : state;

`ifdef HAZARD_PERF_EN
  hazard_perf_counters u_perf (
    .clk             (clk),
    .rst             (rst),
    .stall_evt       (pc_stall),
    .flush_evt       (ifid_flush),
    .freeze_evt      (freeze),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_freeze_cnt (perf_freeze_cnt)
  );
`else
  assign perf_stall_cnt  = 32'd0;
  assign perf_flush_cnt  = 32'd0;
  assign perf_freeze_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MEM_TIMEOUT=4): table vectors,
// hand-written multi-cycle sequences and randomized traffic against a reference model.
// Perf counter expectations follow HAZARD_PERF_EN when it is defined for the bench build.
module tb_hazard_unit;

  localparam int TO = 4;

  logic       clk;
  logic       rst;
  logic [3:0] id_rs, id_rt, dx_rd;
  logic       id_uses_rs, id_uses_rt, dx_memread, ex_branch_taken, mem_req, mem_ready;
  logic       pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, freeze, mem_timeout;
  logic [1:0] hz_state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;

  hazard_unit #(.REG_W(4), .MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .dx_memread(dx_memread), .dx_rd(dx_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .freeze(freeze),
    .mem_timeout(mem_timeout), .hz_state(hz_state),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_freeze_cnt(perf_freeze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit      m_waiting;   // an access is outstanding and the pipe is frozen on it
  bit      m_err;       // the wait ran too long; locked until reset
  int      m_waited;    // freeze cycles spent on the current access
  longint  m_nstall, m_nflush, m_nfreeze;

  task automatic model_check_and_update();
    bit hazard, e_frz, e_flush, e_stall;
    int e_state;
    hazard = dx_memread && (dx_rd != 0) &&
             ((id_uses_rs && id_rs == dx_rd) || (id_uses_rt && id_rt == dx_rd));
    if (rst) begin
      e_frz = 0; e_flush = 0; e_stall = 0; e_state = 0;
    end else begin
      if (m_err)          e_frz = 1;
      else if (m_waiting) e_frz = !mem_ready;
      else                e_frz = mem_req && !mem_ready;
      e_flush = !m_err && !m_waiting && !e_frz && ex_branch_taken;
      e_stall = !m_err && !m_waiting && !e_frz && !ex_branch_taken && hazard;
      e_state = m_err ? 2 : (m_waiting ? 1 : 0);
    end
    chk("m_freeze",      freeze,      e_frz);
    chk("m_ifid_flush",  ifid_flush,  e_flush);
    chk("m_idex_flush",  idex_flush,  e_flush);
    chk("m_pc_stall",    pc_stall,    e_stall);
    chk("m_ifid_stall",  ifid_stall,  e_stall);
    chk("m_idex_bubble", idex_bubble, e_stall);
    chk("m_mem_timeout", mem_timeout, (!rst && m_err) ? 1 : 0);
    chk("m_hz_state",    hz_state,    e_state);
`ifdef HAZARD_PERF_EN
    chk("m_perf_stall",  perf_stall_cnt,  m_nstall[31:0]);
    chk("m_perf_flush",  perf_flush_cnt,  m_nflush[31:0]);
    chk("m_perf_freeze", perf_freeze_cnt, m_nfreeze[31:0]);
`else
    chk("m_perf_stall",  perf_stall_cnt,  0);
    chk("m_perf_flush",  perf_flush_cnt,  0);
    chk("m_perf_freeze", perf_freeze_cnt, 0);
`endif
    // advance to next cycle
    if (rst) begin
      m_waiting = 0; m_err = 0; m_waited = 0;
      m_nstall = 0; m_nflush = 0; m_nfreeze = 0;
    end else begin
      m_nstall  += e_stall;
      m_nflush  += e_flush;
      m_nfreeze += e_frz;
      if (m_waiting && mem_ready) begin
        m_waiting = 0; m_waited = 0;
      end else if (m_waiting) begin
        m_waited++;
        if (m_waited == TO) begin m_err = 1; m_waiting = 0; end
      end else if (!m_err && mem_req && !mem_ready) begin
        m_waiting = 1; m_waited = 1;
      end
    end
  endtask

  // Sample point is the falling edge; drive changes land #1 after the rising edge.
  task automatic end_cycle();
    model_check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    dx_memread = 0; dx_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    @(negedge clk);
    end_cycle();
    rst = 0;
  endtask

  task automatic set_load_use(input logic [3:0] r);
    dx_memread = 1; dx_rd = r; id_rs = r; id_uses_rs = 1; id_rt = 4'hf; id_uses_rt = 0;
  endtask

  // ---------------- table vectors (all stay in RUN) ----------------
  typedef struct {
    string      nm;
    logic [3:0] rs, rt, rd;
    logic       urs, urt, memread, br, req, rdy;
    logic [5:0] exp;   // {freeze, pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush}
  } vec_t;

  vec_t vt[9];

  initial begin
    rst = 1; idle_inputs();
    m_waiting = 0; m_err = 0; m_waited = 0; m_nstall = 0; m_nflush = 0; m_nfreeze = 0;

    vt[0] = '{"lu_rs",        4'h3, 4'h0, 4'h3, 1, 0, 1, 0, 0, 0, 6'b011100};
    vt[1] = '{"lu_rd_zero",   4'h0, 4'h0, 4'h0, 1, 1, 1, 0, 0, 0, 6'b000000};
    vt[2] = '{"br_beats_lu",  4'h3, 4'h0, 4'h3, 1, 0, 1, 1, 0, 0, 6'b000011};
    vt[3] = '{"lu_rt",        4'h1, 4'h5, 4'h5, 0, 1, 1, 0, 0, 0, 6'b011100};
    vt[4] = '{"rt_unused",    4'h1, 4'h5, 4'h5, 0, 0, 1, 0, 0, 0, 6'b000000};
    vt[5] = '{"not_load",     4'h7, 4'h7, 4'h7, 1, 1, 0, 0, 0, 0, 6'b000000};
    vt[6] = '{"zero_wait_lu", 4'h9, 4'h0, 4'h9, 1, 0, 1, 0, 1, 1, 6'b011100};
    vt[7] = '{"br_only",      4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 6'b000011};
    vt[8] = '{"rs_unused",    4'h2, 4'h4, 4'h2, 0, 1, 1, 0, 0, 0, 6'b000000};

    // reset state
    @(negedge clk);
    chk("rst_hz_state", hz_state, 0);
    chk("rst_freeze", freeze, 0);
    end_cycle();
    rst = 0;
    @(negedge clk);
    chk("post_rst_hz_state", hz_state, 0);
    chk("post_rst_timeout", mem_timeout, 0);
    end_cycle();

    for (int i = 0; i < 9; i++) begin
      id_rs = vt[i].rs; id_rt = vt[i].rt; dx_rd = vt[i].rd;
      id_uses_rs = vt[i].urs; id_uses_rt = vt[i].urt; dx_memread = vt[i].memread;
      ex_branch_taken = vt[i].br; mem_req = vt[i].req; mem_ready = vt[i].rdy;
      @(negedge clk);
      chk({"tbl_", vt[i].nm}, {freeze, pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush},
          vt[i].exp);
      chk({"tbl_state_", vt[i].nm}, hz_state, 0);
      end_cycle();
    end

    // memory wait: 3 freeze cycles, ready on the 4th; branch + load-use asserted throughout
    do_reset();
    set_load_use(4'h3); ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_freeze", freeze, 1);
      chk("mw_state", hz_state, (i == 0) ? 2'b00 : 2'b01);
      chk("mw_others", {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush}, 0);
      end_cycle();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("mw_ready_freeze", freeze, 0);
    chk("mw_ready_state", hz_state, 2'b01);
    chk("mw_ready_others", {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush}, 0);
    end_cycle();
    idle_inputs();
    @(negedge clk);
    chk("mw_back_run", hz_state, 2'b00);
    end_cycle();

    // timeout: ready held low
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_wait_timeout", mem_timeout, 0);
      end_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 1);
      @(negedge clk);
      chk("to_err_state", hz_state, 2'b10);
      chk("to_err_flag", mem_timeout, 1);
      chk("to_err_freeze", freeze, 1);
      end_cycle();
    end
    rst = 1;
    @(negedge clk);
    chk("to_rst_outputs", {freeze, mem_timeout, hz_state}, 0);
    end_cycle();
    rst = 0; idle_inputs();
    @(negedge clk);
    chk("to_after_rst_state", hz_state, 2'b00);
    chk("to_after_rst_flag", mem_timeout, 0);
    end_cycle();

    // reset during the second MEM_WAIT cycle
    mem_req = 1; mem_ready = 0;
    @(negedge clk); end_cycle();
    @(negedge clk); end_cycle();
    rst = 1;
    @(negedge clk);
    chk("rmw_all_zero", {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
                         freeze, mem_timeout, hz_state}, 0);
    end_cycle();
    rst = 0; idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rmw_quiet", {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
                        freeze, mem_timeout, hz_state}, 0);
      end_cycle();
    end

    // perf: 2 load-use stalls, 1 flush, 3 freeze cycles
    do_reset();
    set_load_use(4'h6);
    @(negedge clk); end_cycle();
    @(negedge clk); end_cycle();
    idle_inputs(); ex_branch_taken = 1;
    @(negedge clk); end_cycle();
    idle_inputs(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); end_cycle(); end
    mem_ready = 1;
    @(negedge clk); end_cycle();
    idle_inputs();
    @(negedge clk);
`ifdef HAZARD_PERF_EN
    chk("perf_stall", perf_stall_cnt, 2);
    chk("perf_flush", perf_flush_cnt, 1);
    chk("perf_freeze", perf_freeze_cnt, 3);
`else
    chk("perf_stall", perf_stall_cnt, 0);
    chk("perf_flush", perf_flush_cnt, 0);
    chk("perf_freeze", perf_freeze_cnt, 0);
`endif
    end_cycle();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 24) == 0);
      id_rs = 4'($urandom_range(0, 3)); id_rt = 4'($urandom_range(0, 3));
      dx_rd = 4'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      dx_memread = 1'($urandom); ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req = 1'($urandom); mem_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      end_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
